// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the single X->W writeback port among execute units.
// A one-entry output register decouples the units from the writeback stage.
module writeback_arbiter #(
    parameter  int p_num_units    = 3,
    parameter  int p_addr_bits    = 32,
    parameter  int p_data_bits    = 32,
    parameter  int p_seq_num_bits = 8,
    localparam int SRC_W          = $clog2(p_num_units)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [p_num_units-1:0]                 x_val,
    output logic [p_num_units-1:0]                 x_rdy,
    input  logic [p_num_units*p_addr_bits-1:0]     x_pc,
    input  logic [p_num_units*p_seq_num_bits-1:0]  x_seq_num,
    input  logic [p_num_units*5-1:0]               x_waddr,
    input  logic [p_num_units*p_data_bits-1:0]     x_wdata,
    input  logic [p_num_units-1:0]                 x_wen,
    output logic                                   w_val,
    input  logic                                   w_rdy,
    output logic [p_addr_bits-1:0]                 w_pc,
    output logic [p_seq_num_bits-1:0]              w_seq_num,
    output logic [4:0]                             w_waddr,
    output logic [p_data_bits-1:0]                 w_wdata,
    output logic                                   w_wen,
    output logic [SRC_W-1:0]                       w_src
);

    logic                      val_q, val_d;
    logic [SRC_W-1:0]          prio_q, prio_d;
    logic [p_addr_bits-1:0]    pc_q, pc_d;
    logic [p_seq_num_bits-1:0] seq_q, seq_d;
    logic [4:0]                waddr_q, waddr_d;
    logic [p_data_bits-1:0]    wdata_q, wdata_d;
    logic                      wen_q, wen_d;
    logic [SRC_W-1:0]          src_q, src_d;

    logic                      grant_val;
    logic [SRC_W-1:0]          grant_idx;
    logic                      can_accept;
    logic                      xfer;

    // Rotating priority scan starting at prio_q.
    always_comb begin
        int idx;
        grant_val = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < p_num_units; k++) begin
            idx = int'(prio_q) + k;
            if (idx >= p_num_units) begin
                idx = idx - p_num_units;
            end
            if (!grant_val && x_val[idx]) begin
                grant_val = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
    end

    // A draining entry frees the register in the same cycle, so refill is allowed.
    assign can_accept = !val_q || w_rdy;
    assign xfer       = rst && grant_val && can_accept;

    always_comb begin
        x_rdy = '0;
        for (int i = 0; i < p_num_units; i++) begin
            x_rdy[i] = xfer && (int'(grant_idx) == i);
        end
    end

    always_comb begin
        val_d   = val_q;
        prio_d  = prio_q;
        pc_d    = pc_q;
        seq_d   = seq_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        src_d   = src_q;
        if (xfer) begin
            val_d   = 1'b1;
            pc_d    = x_pc[int'(grant_idx)*p_addr_bits +: p_addr_bits];
            seq_d   = x_seq_num[int'(grant_idx)*p_seq_num_bits +: p_seq_num_bits];
            waddr_d = x_waddr[int'(grant_idx)*5 +: 5];
            wdata_d = x_wdata[int'(grant_idx)*p_data_bits +: p_data_bits];
            wen_d   = x_wen[grant_idx];
            src_d   = grant_idx;
            prio_d  = (grant_idx == SRC_W'(p_num_units - 1)) ? '0 : grant_idx + 1'b1;
        end else if (val_q && w_rdy) begin
            val_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            val_q  <= 1'b0;
            prio_q <= '0;
        end else begin
            val_q  <= val_d;
            prio_q <= prio_d;
        end
    end

    // Payload is qualified by val_q, so it carries no reset.
    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        seq_q   <= seq_d;
        waddr_q <= waddr_d;
        wdata_q <= wdata_d;
        wen_q   <= wen_d;
        src_q   <= src_d;
    end

    assign w_val     = val_q && rst;
    assign w_pc      = pc_q;
    assign w_seq_num = seq_q;
    assign w_waddr   = waddr_q;
    assign w_wdata   = wdata_q;
    assign w_wen     = wen_q;
    assign w_src     = src_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_writeback_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 8;
    localparam int GW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    x_val, x_rdy, x_wen;
    logic [N*AW-1:0] x_pc;
    logic [N*SW-1:0] x_seq_num;
    logic [N*5-1:0]  x_waddr;
    logic [N*DW-1:0] x_wdata;
    logic            w_val, w_rdy, w_wen;
    logic [AW-1:0]   w_pc;
    logic [SW-1:0]   w_seq_num;
    logic [4:0]      w_waddr;
    logic [DW-1:0]   w_wdata;
    logic [GW-1:0]   w_src;

    logic [AW-1:0] pc [N];
    logic [SW-1:0] seq[N];
    logic [4:0]    wa [N];
    logic [DW-1:0] wd [N];

    int ncmp  = 0;
    int nfail = 0;

    // Reference model: the result held for writeback plus the next unit in line.
    logic          m_val;
    logic [AW-1:0] m_pc;
    logic [SW-1:0] m_seq;
    logic [4:0]    m_wa;
    logic [DW-1:0] m_wd;
    logic          m_wen;
    int            m_src;
    int            m_prio;

    logic [N-1:0]  obs_rdy;
    logic          obs_wval;
    logic [SW-1:0] held_seq;
    logic [DW-1:0] held_wd;
    logic [GW-1:0] held_src;

    writeback_arbiter #(
        .p_num_units(N), .p_addr_bits(AW), .p_data_bits(DW), .p_seq_num_bits(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .x_val(x_val), .x_rdy(x_rdy), .x_pc(x_pc), .x_seq_num(x_seq_num),
        .x_waddr(x_waddr), .x_wdata(x_wdata), .x_wen(x_wen),
        .w_val(w_val), .w_rdy(w_rdy), .w_pc(w_pc), .w_seq_num(w_seq_num),
        .w_waddr(w_waddr), .w_wdata(w_wdata), .w_wen(w_wen), .w_src(w_src)
    );

    always #5 clk = ~clk;

    always_comb begin
        x_pc      = '0;
        x_seq_num = '0;
        x_waddr   = '0;
        x_wdata   = '0;
        for (int i = 0; i < N; i++) begin
            x_pc[i*AW +: AW]      = pc[i];
            x_seq_num[i*SW +: SW] = seq[i];
            x_waddr[i*5 +: 5]     = wa[i];
            x_wdata[i*DW +: DW]   = wd[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            pc[i]    = $urandom;
            seq[i]   = SW'($urandom);
            wa[i]    = 5'($urandom);
            wd[i]    = $urandom;
            x_wen[i] = 1'($urandom);
        end
    endtask

    // One clock: apply inputs at the falling edge, check, then advance the model.
    task automatic step(input logic r, input logic [N-1:0] xv, input logic wr);
        int           g;
        logic         ev;
        logic [N-1:0] er;
        rst   = r;
        x_val = xv;
        w_rdy = wr;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int u = (m_prio + k) % N;
            if (g < 0 && xv[u]) g = u;
        end
        ev = r && m_val;
        er = '0;
        if (r && g >= 0 && (!m_val || wr)) er[g] = 1'b1;
        chk("x_rdy", 64'(x_rdy), 64'(er));
        chk("w_val", 64'(w_val), 64'(ev));
        if (ev) begin
            chk("w_pc",      64'(w_pc),      64'(m_pc));
            chk("w_seq_num", 64'(w_seq_num), 64'(m_seq));
            chk("w_waddr",   64'(w_waddr),   64'(m_wa));
            chk("w_wdata",   64'(w_wdata),   64'(m_wd));
            chk("w_wen",     64'(w_wen),     64'(m_wen));
            chk("w_src",     64'(w_src),     64'(m_src));
        end
        obs_rdy  = x_rdy;
        obs_wval = w_val;
        @(posedge clk);
        if (!r) begin
            m_val  = 1'b0;
            m_prio = 0;
        end else if (er != '0) begin
            m_val  = 1'b1;
            m_pc   = pc[g];
            m_seq  = seq[g];
            m_wa   = wa[g];
            m_wd   = wd[g];
            m_wen  = x_wen[g];
            m_src  = g;
            m_prio = (g + 1) % N;
        end else if (m_val && wr) begin
            m_val = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        m_val  = 1'b0;
        m_prio = 0;
        m_pc = '0; m_seq = '0; m_wa = '0; m_wd = '0; m_wen = 1'b0; m_src = 0;
        rst = 1'b0; x_val = '0; w_rdy = 1'b0;
        rand_fields();
        @(negedge clk);

        // Reset held with every unit requesting.
        repeat (3) begin
            step(1'b0, 3'b111, 1'b1);
            chk("rst_x_rdy", 64'(obs_rdy), 64'd0);
            chk("rst_w_val", 64'(obs_wval), 64'd0);
        end
        step(1'b1, 3'b111, 1'b1);
        chk("post_rst_grant0", 64'(obs_rdy), 64'b001);
        step(1'b1, 3'b000, 1'b1);
        step(1'b1, 3'b000, 1'b1);

        // Single requester; prio is 1 here.
        rand_fields();
        wd[1] = 32'h1234;
        step(1'b1, 3'b010, 1'b1);
        chk("single_x_rdy", 64'(obs_rdy), 64'b010);
        chk("single_w_val", 64'(w_val), 64'd1);
        chk("single_wdata", 64'(w_wdata), 64'h1234);
        chk("single_src", 64'(w_src), 64'd1);

        // prio is 2: unit 0 wins over unit 1, then unit 1 is next.
        step(1'b1, 3'b011, 1'b1);
        chk("wrap_grant0", 64'(obs_rdy), 64'b001);
        step(1'b1, 3'b011, 1'b1);
        chk("wrap_next1", 64'(obs_rdy), 64'b010);

        // Bring prio to 0, then all units valid at full throughput.
        step(1'b1, 3'b100, 1'b1);
        for (int i = 0; i < 6; i++) begin
            rand_fields();
            step(1'b1, 3'b111, 1'b1);
            chk("rr_x_rdy", 64'(obs_rdy), 64'(1 << (i % 3)));
            chk("rr_src", 64'(w_src), 64'(i % 3));
            chk("rr_w_val", 64'(w_val), 64'd1);
        end

        // Backpressure with unit 2's result held.
        held_seq = w_seq_num;
        held_wd  = w_wdata;
        held_src = w_src;
        repeat (4) begin
            rand_fields();
            step(1'b1, 3'b111, 1'b0);
            chk("bp_x_rdy", 64'(obs_rdy), 64'd0);
            chk("bp_seq", 64'(w_seq_num), 64'(held_seq));
            chk("bp_wdata", 64'(w_wdata), 64'(held_wd));
            chk("bp_src", 64'(w_src), 64'(held_src));
        end
        step(1'b1, 3'b111, 1'b1);
        chk("bp_refill_rdy", 64'(obs_rdy), 64'b001);
        chk("bp_refill_val", 64'(w_val), 64'd1);
        chk("bp_refill_src", 64'(w_src), 64'd0);

        // Reset while a result is held.
        seq[1] = 8'h05;
        step(1'b1, 3'b010, 1'b1);
        chk("midrst_seq", 64'(w_seq_num), 64'h05);
        step(1'b0, 3'b000, 1'b0);
        chk("midrst_rdy", 64'(obs_rdy), 64'd0);
        step(1'b1, 3'b000, 1'b0);
        chk("midrst_discard", 64'(obs_wval), 64'd0);

        // Random traffic with occasional reset.
        for (int c = 0; c < 400; c++) begin
            rand_fields();
            step(($urandom_range(0, 39) != 0), N'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
